// File: rtl/ssm_wr.sv
// ssm_wr: write-side packet storage stage in front of the shared 2048 x 134
// packet RAM. Packets are laid out contiguously in a ring starting at the
// committed head pointer; on the tail word a descriptor (start, length) is
// handed to the LCM. Packets are dropped whole when ring space is short or
// when they exceed MAX_PKT_WORDS. Space returned by the LCM is credited back.
module ssm_wr #(
  parameter string PLATFORM      = "Xilinx-OpenBox-S4",
  parameter int    MAX_PKT_WORDS = 96
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [133:0] in_ssm_wr_data,
  input  logic         in_ssm_wr_data_wr,
  input  logic         lcm2ssm_free,
  input  logic [11:0]  lcm2ssm_free_len,
  output logic         ram_wr,
  output logic [10:0]  ram_wr_addr,
  output logic [133:0] ram_wr_data,
  output logic         out_ssm_wr_desc_wr,
  output logic [10:0]  out_ssm_wr_addr,
  output logic [11:0]  out_ssm_wr_len,
  output logic [11:0]  out_ssm_free_cnt,
  output logic [31:0]  out_ssm_drop_cnt
);

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    WRITE_S = 2'd1,
    DROP_S  = 2'd2
  } state_t;

  localparam logic [1:0]  TAG_HEAD   = 2'b01;
  localparam logic [1:0]  TAG_MID    = 2'b11;
  localparam logic [1:0]  TAG_TAIL   = 2'b10;
  localparam logic [12:0] RING_WORDS = 13'd2048;
  localparam logic [12:0] MAX_W13    = 13'(MAX_PKT_WORDS);
  localparam logic [11:0] MAX_W12    = 12'(MAX_PKT_WORDS);

  state_t       state;
  logic [10:0]  wr_ptr;
  logic [10:0]  cur_ptr;
  logic [10:0]  start;
  logic [11:0]  len;
  logic [11:0]  used;

  logic [1:0]   tag;
  logic         head_in;
  logic         mid_in;
  logic         tail_in;
  logic         space_ok;
  logic         start_pkt;
  logic         reject_head;
  logic         body_ok;
  logic         oversize;
  logic         commit;
  logic         drop_event;
  logic [11:0]  commit_len;
  logic [12:0]  used_plus;
  logic [12:0]  free_amt;
  logic [11:0]  used_next;

  // Decode the incoming word and decide this cycle's action and space update.
  // A head is handled identically in every state: an in-progress packet is
  // simply abandoned (wr_ptr never moved) and the new one restarts at wr_ptr.
  always_comb begin
    tag         = in_ssm_wr_data[133:132];
    head_in     = in_ssm_wr_data_wr && (tag == TAG_HEAD);
    mid_in      = in_ssm_wr_data_wr && (tag == TAG_MID);
    tail_in     = in_ssm_wr_data_wr && (tag == TAG_TAIL);
    space_ok    = ({1'b0, used} + MAX_W13) <= RING_WORDS;
    start_pkt   = head_in && space_ok;
    reject_head = head_in && !space_ok;
    body_ok     = (state == WRITE_S) && (mid_in || tail_in) && (len < MAX_W12);
    oversize    = (state == WRITE_S) && (mid_in || tail_in) && (len >= MAX_W12);
    commit      = body_ok && tail_in;
    drop_event  = reject_head || oversize;
    commit_len  = commit ? (len + 12'd1) : 12'd0;
    used_plus   = {1'b0, used} + {1'b0, commit_len};
    free_amt    = lcm2ssm_free ? {1'b0, lcm2ssm_free_len} : 13'd0;
    used_next   = (used_plus > free_amt) ? 12'(used_plus - free_amt) : 12'd0;
  end

  // Packet FSM with all outputs registered: RAM write one cycle after the
  // accepted word, descriptor pulse on commit, space and drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE_S;
      wr_ptr             <= 11'd0;
      cur_ptr            <= 11'd0;
      start              <= 11'd0;
      len                <= 12'd0;
      used               <= 12'd0;
      ram_wr             <= 1'b0;
      ram_wr_addr        <= 11'd0;
      ram_wr_data        <= 134'd0;
      out_ssm_wr_desc_wr <= 1'b0;
      out_ssm_wr_addr    <= 11'd0;
      out_ssm_wr_len     <= 12'd0;
      out_ssm_free_cnt   <= 12'(RING_WORDS);
      out_ssm_drop_cnt   <= 32'd0;
    end else begin
      ram_wr             <= 1'b0;
      out_ssm_wr_desc_wr <= 1'b0;
      used               <= used_next;
      out_ssm_free_cnt   <= 12'(RING_WORDS - {1'b0, used_next});

      if (drop_event && (out_ssm_drop_cnt != 32'hFFFF_FFFF)) begin
        out_ssm_drop_cnt <= out_ssm_drop_cnt + 32'd1;
      end

      if (start_pkt) begin
        ram_wr      <= 1'b1;
        ram_wr_addr <= wr_ptr;
        ram_wr_data <= in_ssm_wr_data;
        start       <= wr_ptr;
        cur_ptr     <= wr_ptr + 11'd1;
        len         <= 12'd1;
        state       <= WRITE_S;
      end else if (reject_head) begin
        len   <= 12'd0;
        state <= DROP_S;
      end else if (body_ok) begin
        ram_wr      <= 1'b1;
        ram_wr_addr <= cur_ptr;
        ram_wr_data <= in_ssm_wr_data;
        if (tail_in) begin
          out_ssm_wr_desc_wr <= 1'b1;
          out_ssm_wr_addr    <= start;
          out_ssm_wr_len     <= len + 12'd1;
          wr_ptr             <= cur_ptr + 11'd1;
          len                <= 12'd0;
          state              <= IDLE_S;
        end else begin
          cur_ptr <= cur_ptr + 11'd1;
          len     <= len + 12'd1;
        end
      end else if (oversize) begin
        len   <= 12'd0;
        state <= mid_in ? DROP_S : IDLE_S;
      end else if ((state == DROP_S) && tail_in) begin
        state <= IDLE_S;
      end
    end
  end

endmodule

// File: tb/tb_ssm_wr.sv
// tb_ssm_wr: self-checking bench for ssm_wr. A packet-level reference model
// (ring base, word count, used space) predicts every cycle's outputs; a
// vector table and directed sequences pin down the documented corner cases.
module tb_ssm_wr;

  localparam int MAXW = 96;

  logic         clk;
  logic         rst;
  logic [133:0] in_data;
  logic         in_wr;
  logic         fr;
  logic [11:0]  fr_len;
  logic         ram_wr;
  logic [10:0]  ram_wr_addr;
  logic [133:0] ram_wr_data;
  logic         desc_wr;
  logic [10:0]  desc_addr;
  logic [11:0]  desc_len;
  logic [11:0]  free_cnt;
  logic [31:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  // reference model state
  int     m_used;
  int     m_base;
  int     m_cnt;
  bit     m_in;
  longint m_drop;

  // observations of the DUT for directed checks
  int wr_cnt = 0;
  int desc_cnt = 0;
  int last_daddr = -1;
  int last_dlen = -1;
  int wr_addrs[$];

  typedef struct {
    logic        wr;
    logic [1:0]  tag;
    logic        fr;
    logic [11:0] flen;
    logic        e_ram_wr;
    int          e_addr;
    logic        e_desc;
    int          e_daddr;
    int          e_dlen;
    int          e_free;
    int          e_drop;
  } vec_t;

  vec_t vecs[10];

  ssm_wr #(.PLATFORM("Xilinx-OpenBox-S4"), .MAX_PKT_WORDS(MAXW)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_ssm_wr_data    (in_data),
    .in_ssm_wr_data_wr (in_wr),
    .lcm2ssm_free      (fr),
    .lcm2ssm_free_len  (fr_len),
    .ram_wr            (ram_wr),
    .ram_wr_addr       (ram_wr_addr),
    .ram_wr_data       (ram_wr_data),
    .out_ssm_wr_desc_wr(desc_wr),
    .out_ssm_wr_addr   (desc_addr),
    .out_ssm_wr_len    (desc_len),
    .out_ssm_free_cnt  (free_cnt),
    .out_ssm_drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkData(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_used = 0;
    m_base = 0;
    m_cnt  = 0;
    m_in   = 1'b0;
    m_drop = 0;
  endtask

  task automatic modelDrop();
    if (m_drop < 64'hFFFF_FFFF) m_drop++;
  endtask

  // one clock: drive inputs, predict with the model, compare after the edge
  task automatic applyStimulus(input logic wr, input logic [1:0] tag, input logic f, input logic [11:0] flen);
    logic [159:0] rnd;
    logic [133:0] word;
    logic ew, ed;
    int eaddr, edaddr, edlen, commit;
    rnd  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    word = {tag, rnd[131:0]};
    in_data = word;
    in_wr   = wr;
    fr      = f;
    fr_len  = flen;
    ew = 1'b0; ed = 1'b0; eaddr = 0; edaddr = 0; edlen = 0; commit = 0;
    if (wr && tag == 2'b01) begin
      if (m_used + MAXW <= 2048) begin
        ew = 1'b1; eaddr = m_base; m_cnt = 1; m_in = 1'b1;
      end else begin
        modelDrop(); m_in = 1'b0;
      end
    end else if (wr && (tag == 2'b11 || tag == 2'b10) && m_in) begin
      if (m_cnt < MAXW) begin
        ew = 1'b1; eaddr = (m_base + m_cnt) % 2048; m_cnt++;
        if (tag == 2'b10) begin
          ed = 1'b1; edaddr = m_base; edlen = m_cnt; commit = m_cnt;
          m_base = (m_base + m_cnt) % 2048; m_in = 1'b0;
        end
      end else begin
        modelDrop(); m_in = 1'b0;
      end
    end
    m_used = m_used + commit - (f ? int'(flen) : 0);
    if (m_used < 0) m_used = 0;
    @(posedge clk);
    #1;
    checkOutput("ram_wr", ram_wr, ew);
    if (ew) begin
      checkOutput("ram_wr_addr", ram_wr_addr, eaddr);
      checkData("ram_wr_data", ram_wr_data, word);
    end
    checkOutput("desc_wr", desc_wr, ed);
    if (ed) begin
      checkOutput("desc_addr", desc_addr, edaddr);
      checkOutput("desc_len", desc_len, edlen);
    end
    checkOutput("free_cnt", free_cnt, 2048 - m_used);
    checkOutput("drop_cnt", drop_cnt, m_drop);
    if (ram_wr === 1'b1) begin
      wr_cnt++;
      wr_addrs.push_back(int'(ram_wr_addr));
    end
    if (desc_wr === 1'b1) begin
      desc_cnt++;
      last_daddr = int'(desc_addr);
      last_dlen  = int'(desc_len);
    end
  endtask

  task automatic doReset();
    rst = 1'b1; in_wr = 1'b0; in_data = '0; fr = 1'b0; fr_len = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    checkOutput("rst ram_wr", ram_wr, 0);
    checkOutput("rst ram_wr_addr", ram_wr_addr, 0);
    checkData("rst ram_wr_data", ram_wr_data, '0);
    checkOutput("rst desc_wr", desc_wr, 0);
    checkOutput("rst desc_addr", desc_addr, 0);
    checkOutput("rst desc_len", desc_len, 0);
    checkOutput("rst free_cnt", free_cnt, 2048);
    checkOutput("rst drop_cnt", drop_cnt, 0);
  endtask

  task automatic sendPkt(input int n, input logic f, input logic [11:0] flen);
    applyStimulus(1'b1, 2'b01, 1'b0, 12'd0);
    for (int i = 0; i < n - 2; i++) applyStimulus(1'b1, 2'b11, 1'b0, 12'd0);
    applyStimulus(1'b1, 2'b10, f, flen);
  endtask

  initial begin
    int d0, wc, dc;
    int exp_a[4];

    // wr tag fr flen | ram_wr addr desc daddr dlen free drop
    vecs[0] = '{1'b1, 2'b01, 1'b0, 12'd0,   1'b1, 0, 1'b0, 0, 0, 2048, 0};
    vecs[1] = '{1'b1, 2'b11, 1'b0, 12'd0,   1'b1, 1, 1'b0, 0, 0, 2048, 0};
    vecs[2] = '{1'b1, 2'b11, 1'b0, 12'd0,   1'b1, 2, 1'b0, 0, 0, 2048, 0};
    vecs[3] = '{1'b1, 2'b10, 1'b0, 12'd0,   1'b1, 3, 1'b1, 0, 4, 2044, 0};
    vecs[4] = '{1'b0, 2'b01, 1'b0, 12'd0,   1'b0, 0, 1'b0, 0, 0, 2044, 0};
    vecs[5] = '{1'b0, 2'b00, 1'b1, 12'd4,   1'b0, 0, 1'b0, 0, 0, 2048, 0};
    vecs[6] = '{1'b1, 2'b00, 1'b0, 12'd0,   1'b0, 0, 1'b0, 0, 0, 2048, 0};
    vecs[7] = '{1'b1, 2'b11, 1'b0, 12'd0,   1'b0, 0, 1'b0, 0, 0, 2048, 0};
    vecs[8] = '{1'b1, 2'b01, 1'b0, 12'd0,   1'b1, 4, 1'b0, 0, 0, 2048, 0};
    vecs[9] = '{1'b1, 2'b10, 1'b0, 12'd0,   1'b1, 5, 1'b1, 4, 2, 2046, 0};

    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].tag, vecs[i].fr, vecs[i].flen);
      checkOutput("vec ram_wr", ram_wr, vecs[i].e_ram_wr);
      if (vecs[i].e_ram_wr) checkOutput("vec ram_wr_addr", ram_wr_addr, vecs[i].e_addr);
      checkOutput("vec desc_wr", desc_wr, vecs[i].e_desc);
      if (vecs[i].e_desc) begin
        checkOutput("vec desc_addr", desc_addr, vecs[i].e_daddr);
        checkOutput("vec desc_len", desc_len, vecs[i].e_dlen);
      end
      checkOutput("vec free_cnt", free_cnt, vecs[i].e_free);
      checkOutput("vec drop_cnt", drop_cnt, vecs[i].e_drop);
    end

    // fill the ring until admission fails
    doReset();
    for (int p = 0; p < 21; p++) sendPkt(96, 1'b0, 12'd0);
    checkOutput("fill free_cnt", free_cnt, 32);
    d0 = int'(drop_cnt);
    applyStimulus(1'b1, 2'b01, 1'b0, 12'd0);
    checkOutput("full head dropped", drop_cnt, d0 + 1);
    wc = wr_cnt;
    applyStimulus(1'b1, 2'b11, 1'b0, 12'd0);
    applyStimulus(1'b1, 2'b10, 1'b0, 12'd0);
    checkOutput("dropped pkt no writes", wr_cnt, wc);
    applyStimulus(1'b0, 2'b00, 1'b1, 12'd2016);
    checkOutput("after free free_cnt", free_cnt, 2048);

    // ring wrap
    sendPkt(30, 1'b0, 12'd0);
    checkOutput("pre-wrap desc_addr", last_daddr, 2016);
    checkOutput("pre-wrap desc_len", last_dlen, 30);
    wr_addrs.delete();
    sendPkt(4, 1'b0, 12'd0);
    exp_a[0] = 2046; exp_a[1] = 2047; exp_a[2] = 0; exp_a[3] = 1;
    checkOutput("wrap write count", wr_addrs.size(), 4);
    for (int i = 0; i < 4 && i < wr_addrs.size(); i++) checkOutput("wrap addr", wr_addrs[i], exp_a[i]);
    checkOutput("wrap desc_addr", last_daddr, 2046);
    checkOutput("wrap desc_len", last_dlen, 4);

    // oversize packet
    wc = wr_cnt; dc = desc_cnt; d0 = int'(drop_cnt);
    sendPkt(97, 1'b0, 12'd0);
    checkOutput("oversize writes", wr_cnt - wc, 96);
    checkOutput("oversize no desc", desc_cnt, dc);
    checkOutput("oversize drop", drop_cnt, d0 + 1);
    sendPkt(5, 1'b0, 12'd0);
    checkOutput("after oversize desc_addr", last_daddr, 2);

    // head abort
    dc = desc_cnt; d0 = int'(drop_cnt);
    applyStimulus(1'b1, 2'b01, 1'b0, 12'd0);
    applyStimulus(1'b1, 2'b11, 1'b0, 12'd0);
    applyStimulus(1'b1, 2'b01, 1'b0, 12'd0);
    applyStimulus(1'b1, 2'b11, 1'b0, 12'd0);
    applyStimulus(1'b1, 2'b10, 1'b0, 12'd0);
    checkOutput("abort desc count", desc_cnt, dc + 1);
    checkOutput("abort desc_addr", last_daddr, 7);
    checkOutput("abort desc_len", last_dlen, 3);
    checkOutput("abort no drop", drop_cnt, d0);

    // reset in the middle of a packet
    doReset();
    dc = desc_cnt;
    applyStimulus(1'b1, 2'b01, 1'b0, 12'd0);
    applyStimulus(1'b1, 2'b11, 1'b0, 12'd0);
    doReset();
    checkOutput("mid-reset no desc", desc_cnt, dc);
    sendPkt(4, 1'b0, 12'd0);
    checkOutput("mid-reset desc_addr", last_daddr, 0);
    checkOutput("mid-reset desc_len", last_dlen, 4);

    // commit and free in the same cycle, then free saturation
    doReset();
    sendPkt(20, 1'b0, 12'd0);
    checkOutput("used 20 free_cnt", free_cnt, 2028);
    sendPkt(10, 1'b1, 12'd4);
    checkOutput("commit+free free_cnt", free_cnt, 2022);
    applyStimulus(1'b0, 2'b00, 1'b1, 12'd100);
    checkOutput("free saturate free_cnt", free_cnt, 2048);

    // randomized traffic against the model
    doReset();
    for (int i = 0; i < 6000; i++) begin
      int r;
      logic [1:0] t;
      logic w, f;
      logic [11:0] fl;
      r = int'($urandom_range(0, 99));
      if (i < 3000) t = (r < 8) ? 2'b01 : (r < 83) ? 2'b11 : (r < 95) ? 2'b10 : 2'b00;
      else          t = (r < 2) ? 2'b01 : (r < 98) ? 2'b11 : (r < 99) ? 2'b10 : 2'b00;
      w  = ($urandom_range(0, 9) < 8);
      f  = ($urandom_range(0, 99) < 6);
      fl = 12'($urandom_range(0, 150));
      applyStimulus(w, t, f, fl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
